// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle main controller and the shared datapath.
// master = controller side (drives strobes/selects), slave = datapath/memory side.
interface mc_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] trap_cause;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct3, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               trap_cause, state_o
    );

    modport slave (
        output opcode, funct3, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               trap_cause, state_o
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller for the RV32I core: sequences the shared ALU, memory
// port, IR, PC and register file one instruction at a time; traps on anything else.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  ctrl
);

    if ((2 ** TO_W) <= MEM_TIMEOUT) begin : g_bad_timeout_width
        $error("TO_W too narrow for MEM_TIMEOUT");
    end

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_LOAD_WB  = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R_ALU  = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [TO_W-1:0] r_wait_cnt;
    logic [1:0]      r_trap_cause;
    logic [1:0]      w_trap_cause;
    logic            w_mem_state;
    logic            w_timeout;

    logic       w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write, w_pc_src;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op;
    logic       w_reg_write, w_mem_to_reg;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);
    // Last allowed waiting cycle still accepts mem_ready; only a miss here traps.
    assign w_timeout   = w_mem_state && !ctrl.mem_ready && (r_wait_cnt == WAIT_LAST);

    // NOTE: every signal written below gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_next       = r_state;
        w_trap_cause = r_trap_cause;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end

            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b01;
                if (ctrl.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_trap_cause = CAUSE_MEM_TO;
                end
            end

            S_DECODE: begin
                // ALUOut <= OldPC + imm, the branch target used later by BRANCH.
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b10;
                case (ctrl.opcode)
                    OP_R_ALU:  w_next = S_EXEC_R;
                    OP_I_ALU:  w_next = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE:  w_next = S_MEM_ADDR;
                    OP_BRANCH: begin
                        if ((ctrl.funct3 == F3_BEQ) || (ctrl.funct3 == F3_BNE)) begin
                            w_next = S_BRANCH;
                        end else begin
                            w_next       = S_TRAP;
                            w_trap_cause = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        w_next       = S_TRAP;
                        w_trap_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_next      = (ctrl.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (ctrl.mem_ready) begin
                    w_next = S_LOAD_WB;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_trap_cause = CAUSE_MEM_TO;
                end
            end

            S_LOAD_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_next       = S_FETCH;
            end

            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
                if (ctrl.mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_trap_cause = CAUSE_MEM_TO;
                end
            end

            S_EXEC_R: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b10;
                w_next      = S_ALU_WB;
            end

            S_EXEC_I: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = S_ALU_WB;
            end

            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end

            S_BRANCH: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b01;
                w_pc_src    = 1'b1;
                w_pc_write  = ((ctrl.funct3 == F3_BEQ) &&  ctrl.alu_zero) ||
                              ((ctrl.funct3 == F3_BNE) && !ctrl.alu_zero);
                w_next      = S_FETCH;
            end

            S_TRAP: begin
                w_next = S_TRAP;
            end

            default: begin
                w_next       = S_TRAP;
                w_trap_cause = CAUSE_ILLEGAL;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            r_state      <= w_next;
            r_trap_cause <= w_trap_cause;
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_mem_state && !ctrl.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + TO_W'(1);
            end
        end
    end

    // Outputs decode only r_state (plus inputs), so async reset to IDLE drops every strobe at once.
    assign ctrl.mem_req    = w_mem_req;
    assign ctrl.mem_we     = w_mem_we;
    assign ctrl.iord       = w_iord;
    assign ctrl.ir_write   = w_ir_write;
    assign ctrl.pc_write   = w_pc_write;
    assign ctrl.pc_src     = w_pc_src;
    assign ctrl.alu_src_a  = w_alu_src_a;
    assign ctrl.alu_src_b  = w_alu_src_b;
    assign ctrl.alu_op     = w_alu_op;
    assign ctrl.reg_write  = w_reg_write;
    assign ctrl.mem_to_reg = w_mem_to_reg;
    assign ctrl.trap_cause = r_trap_cause;
    assign ctrl.state_o    = r_state;

endmodule
